// File: rtl/nios_3pio_sw_ctrl.sv
// Avalon-MM slave for the switch PIO: sync, tick-based debounce, edge capture, maskable level IRQ.
// Optional macro SW_CTRL_SYNC_EN inserts a two-flop synchroniser ahead of the sample register.
module nios_3pio_sw_ctrl #(
  parameter int WIDTH     = 4,
  parameter int TICK_DIV  = 50000,
  parameter int DB_TICKS  = 3,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [3:0] DBMAX = 4'(DB_TICKS);

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  logic [WIDTH-1:0] sample_d;
  logic [WIDTH-1:0] sample;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [3:0]       cnt [WIDTH];
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] debounced_prev;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic             wr;

  // Upper writedata bits have no storage behind them.
  wire unused = &{1'b0, writedata};

`ifdef SW_CTRL_SYNC_EN
  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= in_port;
      sync_out  <= sync_meta;
    end
  end

  assign sample_d = sync_out;
`else
  assign sample_d = in_port;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sample <= '0;
    else          sample <= sample_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          presc <= '0;
    else if (presc == PMAX) presc <= '0;
    else                   presc <= presc + 1'b1;
  end

  assign tick = (presc == PMAX);

  // A level is accepted only after DB_TICKS consecutive disagreeing ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      debounced <= '0;
    end else if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sample[i] != debounced[i]) begin
          if (cnt[i] + 4'd1 == DBMAX) begin
            debounced[i] <= sample[i];
            cnt[i]       <= '0;
          end else begin
            cnt[i] <= cnt[i] + 4'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign wr = chipselect && !write_n;

  always_comb begin
    edge_set = '0;
    edge_clr = '0;
    case (EDGE_TYPE)
      1:       edge_set = debounced & ~debounced_prev;
      2:       edge_set = ~debounced & debounced_prev;
      default: edge_set = debounced ^ debounced_prev;
    endcase
    if (wr && address == 2'd3) edge_clr = writedata[WIDTH-1:0];
  end

  // Set has priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      debounced_prev <= '0;
      edge_capture   <= '0;
      irq_mask       <= '0;
    end else begin
      debounced_prev <= debounced;
      edge_capture   <= (edge_capture & ~edge_clr) | edge_set;
      if (wr && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= zext(debounced);
        2'd1:    readdata <= zext(sample);
        2'd2:    readdata <= zext(irq_mask);
        default: readdata <= zext(edge_capture);
      endcase
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_3pio_sw_ctrl.sv
// Directed bench for nios_3pio_sw_ctrl: any-edge instance plus a rising-only instance on the same bus.
module tb_nios_3pio_sw_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] readdata_r;
  logic        irq_r;

  int checks = 0;
  int errors = 0;
  int cyc;

  nios_3pio_sw_ctrl #(.WIDTH(4), .TICK_DIV(4), .DB_TICKS(3), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  nios_3pio_sw_ctrl #(.WIDTH(4), .TICK_DIV(4), .DB_TICKS(3), .EDGE_TYPE(1)) dut_r (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_r), .irq(irq_r)
  );

  always #5 clk = ~clk;

  // Edges since reset release; sample ticks fall on multiples of 4.
  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    address = 2'd0;
    bus_idle();
    in_port = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state readback while in_port is held high
    address = 2'd0;
    go_to(1); check("rst_deb", readdata, 32'h0); address = 2'd1;
    go_to(2); check("rst_sample", readdata, 32'hF); address = 2'd2;
    go_to(3); check("rst_mask", readdata, 32'h0); address = 2'd3;
    go_to(4); check("rst_ec", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    in_port = 4'h0;

    // Clean press on bit 0: sample changes at 9, ticks 12/16/20
    address = 2'd0;
    go_to(8);  in_port = 4'h1;
    go_to(20); check("press_deb_before", readdata, 32'h0);
    go_to(21); check("press_deb_after", readdata, 32'h1); address = 2'd3;
    go_to(22); check("press_ec", readdata, 32'h1);
    check("press_irq_masked", {31'b0, irq}, 32'h0);

    // Mask write; upper writedata bits are dropped
    bus_write(2'd2, 32'hFFFF_FFF1);
    go_to(23); bus_idle(); check("mask_irq", {31'b0, irq}, 32'h1);
    go_to(24); check("mask_read", readdata, 32'h1);
    bus_write(2'd3, 32'h1);
    go_to(25); bus_idle(); check("w1c_irq", {31'b0, irq}, 32'h0);
    go_to(26); check("w1c_ec", readdata, 32'h0);

    // Write to read-only debounced register is ignored
    bus_write(2'd0, 32'hF);
    go_to(27); bus_idle(); address = 2'd0;
    go_to(28); check("ro_deb", readdata, 32'h1);

    // Bounce bit 1: one tick high, one tick low, four times
    for (int k = 0; k < 4; k++) begin
      go_to(28 + 8 * k); in_port[1] = 1'b1;
      go_to(32 + 8 * k); in_port[1] = 1'b0;
    end
    go_to(60); address = 2'd0;
    go_to(61); check("bounce_deb", readdata, 32'h1); address = 2'd3;
    go_to(62); check("bounce_ec", readdata, 32'h0);

    // Release bit 0: debounced falls at 76, edge lands at 77 alongside W1C
    go_to(64); in_port = 4'h0;
    go_to(76); bus_write(2'd3, 32'h1);
    go_to(77); bus_idle();
    check("coll_irq", {31'b0, irq}, 32'h1);
    check("coll_irq_rise_only", {31'b0, irq_r}, 32'h0);
    go_to(78); check("coll_ec", readdata, 32'h1);
    bus_write(2'd3, 32'h1);
    go_to(79); bus_idle(); check("coll_clr_irq", {31'b0, irq}, 32'h0);

    // Bit 2 press then release: rising-only instance captures just the press
    go_to(80); in_port = 4'h4;
    go_to(94); check("rise_press_ec", readdata_r, 32'h4);
    check("any_press_ec", readdata, 32'h4);
    bus_write(2'd3, 32'h4);
    go_to(95); bus_idle();
    go_to(96); in_port = 4'h0;
    go_to(110); check("rise_release_ec", readdata_r, 32'h0);
    check("any_release_ec", readdata, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
